frame_update_scheduler: RTL and testbench

//  Sequences the per-frame scan of the 16x12 snake playfield. Drives cell coordinates to the object lookup,

---
 rtl/frame_update_scheduler.sv | 156 +++++++++++++++
 tb/tb_frame_update_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// Per-frame scan of the snake playfield: compares each cell against
// a shadow of the last drawn frame and issues draw commands for changes.
module frame_update_scheduler #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 12,
  parameter int CODE_W     = 3,
  parameter int LOOKUP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              game_over,
  input  logic [CODE_W-1:0] obj_code,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic              cmd_valid,
  output logic [3:0]        cmd_x,
  output logic [3:0]        cmd_y,
  output logic [CODE_W-1:0] cmd_code,
  input  logic              cmd_done,
  output logic              init_cycle,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);
  localparam int LW = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        r_state;
  logic [3:0]        r_x;
  logic [3:0]        r_y;
  logic [LW-1:0]     r_lat;
  logic              r_force;
  logic              r_init;
  logic              r_overrun;
  logic              r_cmd_valid;
  logic [3:0]        r_cmd_x;
  logic [3:0]        r_cmd_y;
  logic [CODE_W-1:0] r_cmd_code;
  logic [CODE_W-1:0] r_shadow [N];

  logic [AW-1:0]     w_idx;
  logic              w_last_x;
  logic              w_last_y;
  logic              w_hit;
  logic              w_diff;
  logic              w_commit;

  assign w_idx    = AW'(int'(r_y) * GRID_W + int'(r_x));
  assign w_last_x = (r_x == 4'(GRID_W - 1));
  assign w_last_y = (r_y == 4'(GRID_H - 1));
  assign w_hit    = (r_lat == LW'(LOOKUP_LAT));
  assign w_diff   = (obj_code != r_shadow[w_idx]);
  assign w_commit = (r_state == S_WAIT) && cmd_done;

  assign x          = r_x;
  assign y          = r_y;
  assign cmd_valid  = r_cmd_valid;
  assign cmd_x      = r_cmd_x;
  assign cmd_y      = r_cmd_y;
  assign cmd_code   = r_cmd_code;
  assign init_cycle = r_init;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

  // Scan FSM: walk cells row-major, emit a command for each changed cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_lat       <= '0;
      r_force     <= 1'b0;
      r_init      <= 1'b1;
      r_overrun   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_x     <= '0;
      r_cmd_y     <= '0;
      r_cmd_code  <= '0;
    end else begin
      if (frame_start && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_force <= r_init | game_over;
            r_x     <= '0;
            r_y     <= '0;
            r_lat   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_hit) begin
            r_lat <= r_lat + 1'b1;
          end else if (r_force || w_diff) begin
            r_cmd_x     <= r_x;
            r_cmd_y     <= r_y;
            r_cmd_code  <= obj_code;
            r_cmd_valid <= 1'b1;
            r_state     <= S_WAIT;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            r_cmd_valid <= 1'b0;
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last_x && w_last_y) begin
            r_state <= S_DONE;
          end else begin
            if (w_last_x) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
            r_lat   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_init  <= 1'b0;
          r_x     <= '0;
          r_y     <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shadow of the last drawn frame, updated when a draw completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        r_shadow[i] <= '0;
    end else if (w_commit) begin
      r_shadow[w_idx] <= r_cmd_code;
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed and randomized frames for frame_update_scheduler, checked
// against a cell-list reference model of the scan/redraw rules.
module tb_frame_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       game_over;
  logic [2:0] obj_code;
  logic [3:0] x;
  logic [3:0] y;
  logic       cmd_valid;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [2:0] cmd_code;
  logic       cmd_done;
  logic       init_cycle;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cx;
    int cy;
    int code;
  } cmd_t;

  int   map      [192];
  int   shadow_m [192];
  bit   init_m;
  cmd_t expq[$];

  frame_update_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .game_over  (game_over),
    .obj_code   (obj_code),
    .x          (x),
    .y          (y),
    .cmd_valid  (cmd_valid),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_code   (cmd_code),
    .cmd_done   (cmd_done),
    .init_cycle (init_cycle),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // object lookup with one cycle of latency
  always @(posedge clk)
    obj_code <= 3'(map[int'(y) * 16 + int'(x)]);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // every cell that differs from what was drawn (or all, when forced)
  task automatic model_frame(input bit go);
    bit force_all;
    force_all = init_m | go;
    expq.delete();
    for (int cy = 0; cy < 12; cy++)
      for (int cx = 0; cx < 16; cx++) begin
        int i;
        i = cy * 16 + cx;
        if (force_all || map[i] != shadow_m[i]) begin
          expq.push_back('{cx, cy, map[i]});
          shadow_m[i] = map[i];
        end
      end
    init_m = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 192; i++) shadow_m[i] = 0;
    init_m = 1'b1;
  endtask

  task automatic run_frame(input string tag, input bit go,
                           input int dmin, input int dmax,
                           input int pulse_at, input int done_at,
                           input bit pulse_in_done);
    int   cyc, ncmd, nexp, waits, cnt, elapsed;
    bit   fin, active, pulsed;
    cmd_t e;
    logic [3:0] lx, ly;
    logic [2:0] lc;
    model_frame(go);
    nexp = expq.size();
    @(negedge clk);
    frame_start = 1'b1;
    game_over   = go;
    @(negedge clk);
    frame_start = 1'b0;
    game_over   = 1'b0;
    cyc = 0; ncmd = 0; waits = 0; cnt = 0; elapsed = 0;
    fin = 0; active = 0; pulsed = 0;
    lx = '0; ly = '0; lc = '0;
    while (!fin && cyc < 20000) begin
      if (cmd_done) cmd_done = 1'b0;
      if (frame_done) begin
        fin = 1;
        elapsed = cyc;
      end else begin
        frame_start = (cyc == pulse_at);
        if (cyc == done_at && !cmd_valid) cmd_done = 1'b1;
        if (cmd_valid && !active) begin
          active = 1; pulsed = 0; ncmd++;
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk({tag, " cmd_x"}, 32'(cmd_x), 32'(e.cx));
            chk({tag, " cmd_y"}, 32'(cmd_y), 32'(e.cy));
            chk({tag, " cmd_code"}, 32'(cmd_code), 32'(e.code));
          end else begin
            chk({tag, " extra_cmd"}, 32'(ncmd), 32'(nexp));
          end
          lx = cmd_x; ly = cmd_y; lc = cmd_code;
          cnt = $urandom_range(dmax, dmin);
          waits += cnt + 1;
          if (cnt == 0) begin
            cmd_done = 1'b1; pulsed = 1;
          end
        end else if (cmd_valid && active) begin
          chk({tag, " hold_x"}, 32'(cmd_x), 32'(lx));
          chk({tag, " hold_y"}, 32'(cmd_y), 32'(ly));
          chk({tag, " hold_code"}, 32'(cmd_code), 32'(lc));
          if (!pulsed) begin
            if (cnt > 0) cnt--;
            if (cnt == 0) begin
              cmd_done = 1'b1; pulsed = 1;
            end
          end
        end else if (!cmd_valid && active) begin
          active = 0;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    frame_start = 1'b0;
    cmd_done    = 1'b0;
    chk({tag, " finished"}, 32'(fin), 32'd1);
    chk({tag, " n_cmds"}, 32'(ncmd), 32'(nexp));
    chk({tag, " cycles"}, 32'(elapsed), 32'(576 + waits));
    if (pulse_in_done) frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk({tag, " done_pulse"}, 32'(frame_done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " init_cycle"}, 32'(init_cycle), 32'd0);
    @(negedge clk);
    chk({tag, " stay_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k;
    bit seen;
    rst = 1'b1; frame_start = 1'b0; game_over = 1'b0; cmd_done = 1'b0;
    for (int i = 0; i < 192; i++) map[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst cmd_valid", 32'(cmd_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst init", 32'(init_cycle), 1);
    chk("rst xy", 32'({x, y}), 0);
    chk("rst overrun", 32'(overrun), 0);
    rst = 1'b0;

    // reset while a command is pending
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      if (cmd_valid) seen = 1;
      else begin @(negedge clk); k++; end
    end
    chk("wait reached", 32'(seen), 1);
    chk("wait busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst cmd_valid", 32'(cmd_valid), 0);
    chk("arst xy", 32'({x, y}), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst init", 32'(init_cycle), 1);
    chk("arst frame_done", 32'(frame_done), 0);
    chk("arst cmd_fields", 32'({cmd_x, cmd_y, cmd_code}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    run_frame("first", 0, 1, 1, -1, -1, 0);
    run_frame("same", 0, 0, 0, -1, -1, 0);

    for (int cy = 0; cy < 12; cy++)
      for (int cx = 0; cx < 16; cx++)
        if (cx == 0 || cx == 15 || cy == 0 || cy == 11)
          map[cy * 16 + cx] = 4;
    run_frame("border", 0, 0, 3, -1, -1, 0);
    map[4 * 16 + 4] = 1;
    map[4 * 16 + 5] = 2;
    map[4 * 16 + 6] = 3;
    run_frame("snake", 0, 0, 3, -1, -1, 0);
    chk("no overrun yet", 32'(overrun), 0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 192; i++)
        if ($urandom_range(7, 0) == 0) map[i] = $urandom_range(7, 0);
      run_frame("rand", 0, 0, 3, (f == 1) ? 100 : -1, -1, f == 2);
    end
    chk("overrun set", 32'(overrun), 1);

    run_frame("game_over", 1, 0, 2, -1, -1, 0);
    run_frame("after_go", 0, 0, 0, -1, -1, 0);

    map[0] = (map[0] + 1) % 8;
    map[100] = (map[100] + 3) % 8;
    run_frame("stall", 0, 50, 50, -1, 1, 0);
    chk("overrun held", 32'(overrun), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
